// File: rtl/boolfn_lut_eval.sv
// ---------------------------------------------------------------------------
// boolfn_lut_eval
//   Programmable N_IN-input Boolean function held as a 2^N_IN-bit truth table.
//   The table is loaded serially (minterm 0 first), evaluated through a 1-deep
//   valid/ready output register, and can be swept to count its ones.
//
//   Optional feature macro: BOOLFN_PARITY_EN
//     defined   : load is TBL+1 beats; the last beat is even parity over the
//                 table. A mismatch pulses cfg_err, clears the table and
//                 returns to EMPTY.
//     undefined : load is exactly TBL beats; cfg_err is tied 0.
//
//   Ports
//     clk, rst                       clock, asynchronous active-high reset
//     cfg_valid/cfg_bit/cfg_ready    serial table load
//     cfg_err                        1-cycle parity-error pulse
//     in_valid/in_vec/in_ready       evaluation request
//     out_valid/out_f/out_ready      evaluation result
//     sweep_start                    level request to sweep all minterms
//     sweep_busy/sweep_done          sweep in progress / end-of-sweep pulse
//     sweep_count                    ones counted by the last finished sweep
// ---------------------------------------------------------------------------
module boolfn_lut_eval #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned CNT_W = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_vec,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_f,
    input  logic             out_ready,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [CNT_W-1:0] sweep_count
);

    localparam int unsigned TBL   = 1 << N_IN;
    localparam int unsigned IDX_W = N_IN + 1;   // load index also reaches TBL (parity beat)

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_SWEEP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [TBL-1:0]     table_q, table_d;
    logic [IDX_W-1:0]   load_idx_q, load_idx_d;
    logic [N_IN-1:0]    sweep_idx_q, sweep_idx_d;
    logic [CNT_W-1:0]   sweep_acc_q, sweep_acc_d;
    logic [CNT_W-1:0]   sweep_count_q, sweep_count_d;
    logic               sweep_done_q, sweep_done_d;
    logic               out_valid_q, out_valid_d;
    logic               out_f_q, out_f_d;
    logic               cfg_fire;
    logic               in_fire;

    // Handshake decode; cfg beats and sweep requests take priority over evaluation.
    assign cfg_ready = (state_q != S_SWEEP);
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign in_ready  = (state_q == S_RUN) & ~cfg_valid & ~sweep_start
                     & (~out_valid_q | out_ready);
    assign in_fire   = in_valid & in_ready;

`ifdef BOOLFN_PARITY_EN
    logic cfg_err_q, cfg_err_d;
    assign cfg_err = cfg_err_q;
`else
    assign cfg_err = 1'b0;
`endif

    assign out_valid   = out_valid_q;
    assign out_f       = out_f_q;
    assign sweep_busy  = (state_q == S_SWEEP);
    assign sweep_done  = sweep_done_q;
    assign sweep_count = sweep_count_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_EMPTY;
            table_q       <= '0;
            load_idx_q    <= '0;
            sweep_idx_q   <= '0;
            sweep_acc_q   <= '0;
            sweep_count_q <= '0;
            sweep_done_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_f_q       <= 1'b0;
`ifdef BOOLFN_PARITY_EN
            cfg_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            table_q       <= table_d;
            load_idx_q    <= load_idx_d;
            sweep_idx_q   <= sweep_idx_d;
            sweep_acc_q   <= sweep_acc_d;
            sweep_count_q <= sweep_count_d;
            sweep_done_q  <= sweep_done_d;
            out_valid_q   <= out_valid_d;
            out_f_q       <= out_f_d;
`ifdef BOOLFN_PARITY_EN
            cfg_err_q     <= cfg_err_d;
`endif
        end
    end

    // Next-state, table load, sweep and output-register logic.
    always_comb begin
        state_d       = state_q;
        table_d       = table_q;
        load_idx_d    = load_idx_q;
        sweep_idx_d   = sweep_idx_q;
        sweep_acc_d   = sweep_acc_q;
        sweep_count_d = sweep_count_q;
        sweep_done_d  = 1'b0;
`ifdef BOOLFN_PARITY_EN
        cfg_err_d     = 1'b0;
`endif
        // Result register holds while stalled; a later reload cannot disturb it.
        out_valid_d   = in_fire | (out_valid_q & ~out_ready);
        out_f_d       = in_fire ? table_q[in_vec] : out_f_q;

        unique case (state_q)
            S_EMPTY, S_RUN: begin
                if (cfg_fire) begin
                    table_d[0] = cfg_bit;
                    load_idx_d = IDX_W'(1);
                    state_d    = S_LOAD;
                end else if ((state_q == S_RUN) && sweep_start && !out_valid_q) begin
                    sweep_idx_d = '0;
                    sweep_acc_d = '0;
                    state_d     = S_SWEEP;
                end
            end
            S_LOAD: begin
                if (cfg_fire) begin
`ifdef BOOLFN_PARITY_EN
                    if (load_idx_q == IDX_W'(TBL)) begin
                        load_idx_d = '0;
                        if (cfg_bit == ^table_q) begin
                            state_d = S_RUN;
                        end else begin
                            cfg_err_d = 1'b1;
                            table_d   = '0;
                            state_d   = S_EMPTY;
                        end
                    end else begin
                        table_d[load_idx_q[N_IN-1:0]] = cfg_bit;
                        load_idx_d = load_idx_q + IDX_W'(1);
                    end
`else
                    table_d[load_idx_q[N_IN-1:0]] = cfg_bit;
                    if (load_idx_q == IDX_W'(TBL - 1)) begin
                        load_idx_d = '0;
                        state_d    = S_RUN;
                    end else begin
                        load_idx_d = load_idx_q + IDX_W'(1);
                    end
`endif
                end
            end
            S_SWEEP: begin
                sweep_acc_d = sweep_acc_q + CNT_W'(table_q[sweep_idx_q]);
                sweep_idx_d = sweep_idx_q + N_IN'(1);
                if (sweep_idx_q == N_IN'(TBL - 1)) begin
                    sweep_count_d = sweep_acc_d;
                    sweep_done_d  = 1'b1;
                    sweep_idx_d   = '0;
                    state_d       = S_RUN;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

endmodule
